// File: rtl/mem_arb_pkg.sv
// Shared TinyRV1 types for the memory arbiter: FSM states, transaction type codes, request buffer layout.
// No logic; imported by the arbiter, its request buffer and the bench.
// Backpressure: not applicable.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    localparam int REQ_W = $bits(req_t);

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of the two requester ports and the shared memory port around mem_arb.
// Latency: none (wires only).
// Backpressure: val/rdy on every channel; slave is the arbiter's view, master the environment's.
interface mem_arb_if;

    logic        req0_val;
    logic        req0_rdy;
    logic        req0_type;
    logic [31:0] req0_addr;
    logic [31:0] req0_wdata;
    logic        resp0_val;
    logic        resp0_rdy;
    logic [31:0] resp0_rdata;

    logic        req1_val;
    logic        req1_rdy;
    logic        req1_type;
    logic [31:0] req1_addr;
    logic [31:0] req1_wdata;
    logic        resp1_val;
    logic        resp1_rdy;
    logic [31:0] resp1_rdata;

    logic        mem_req_val;
    logic        mem_req_rdy;
    logic        mem_req_type;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_val;
    logic        mem_resp_rdy;
    logic [31:0] mem_resp_rdata;

    modport slave (
        input  req0_val, req0_type, req0_addr, req0_wdata, resp0_rdy,
        input  req1_val, req1_type, req1_addr, req1_wdata, resp1_rdy,
        input  mem_req_rdy, mem_resp_val, mem_resp_rdata,
        output req0_rdy, resp0_val, resp0_rdata,
        output req1_rdy, resp1_val, resp1_rdata,
        output mem_req_val, mem_req_type, mem_req_addr, mem_req_wdata, mem_resp_rdy
    );

    modport master (
        output req0_val, req0_type, req0_addr, req0_wdata, resp0_rdy,
        output req1_val, req1_type, req1_addr, req1_wdata, resp1_rdy,
        output mem_req_rdy, mem_resp_val, mem_resp_rdata,
        input  req0_rdy, resp0_val, resp0_rdata,
        input  req1_rdy, resp1_val, resp1_rdata,
        input  mem_req_val, mem_req_type, mem_req_addr, mem_req_wdata, mem_resp_rdy
    );

endinterface

// File: rtl/mem_arb_reg.sv
// Enabled register with asynchronous clear, used as the arbiter's request buffer.
// Latency: 1 cycle from d to q when en is high.
// Backpressure: none; holds q while en is low.
module mem_arb_reg #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/mem_arb.sv
// Two-port (imem/dmem) arbiter onto one memory, one transaction in flight; MEM_ARB_RR_EN selects round-robin, else dmem priority.
// Latency: accept at cycle 0, mem request at cycle 1, response at cycle 2 with zero-wait memory, next grant at cycle 3.
// Backpressure: requesters see rdy only in IDLE; mem_req_val held until mem_req_rdy; mem_resp_rdy follows the owner's resp_rdy.
module mem_arb
    import mem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    mem_arb_if.slave bus
);

    state_t state;
    logic   owner;
    logic   grant;
    logic   idle;
    logic   req_hs;
    req_t   req_d;
    req_t   req_q;

`ifdef MEM_ARB_RR_EN
    logic last_grant;

    // With nobody asking, the port that would win is still the one after last_grant.
    always_comb begin
        grant = ~last_grant;
        if (bus.req0_val && !bus.req1_val)      grant = 1'b0;
        else if (bus.req1_val && !bus.req0_val) grant = 1'b1;
    end
`else
    assign grant = !(bus.req0_val && !bus.req1_val);
`endif

    // rdy is qualified with rst_n so it drops the moment reset asserts.
    assign idle         = rst_n && (state == IDLE);
    assign bus.req0_rdy = idle && !grant;
    assign bus.req1_rdy = idle &&  grant;
    assign req_hs       = (bus.req0_val && bus.req0_rdy) || (bus.req1_val && bus.req1_rdy);

    assign req_d = grant ? req_t'{bus.req1_type, bus.req1_addr, bus.req1_wdata}
                         : req_t'{bus.req0_type, bus.req0_addr, bus.req0_wdata};

    mem_arb_reg #(
        .WIDTH (REQ_W)
    ) u_req_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (req_hs),
        .d     (req_d),
        .q     (req_q)
    );

    assign bus.mem_req_val   = (state == REQ);
    assign bus.mem_req_type  = req_q.rw;
    assign bus.mem_req_addr  = req_q.addr;
    assign bus.mem_req_wdata = req_q.wdata;

    assign bus.resp0_val    = (state == RESP) && !owner && bus.mem_resp_val;
    assign bus.resp1_val    = (state == RESP) &&  owner && bus.mem_resp_val;
    assign bus.resp0_rdata  = ((state == RESP) && !owner) ? bus.mem_resp_rdata : 32'h0;
    assign bus.resp1_rdata  = ((state == RESP) &&  owner) ? bus.mem_resp_rdata : 32'h0;
    assign bus.mem_resp_rdy = (state == RESP) && (owner ? bus.resp1_rdy : bus.resp0_rdy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_hs) begin
                        state <= REQ;
                        owner <= grant;
`ifdef MEM_ARB_RR_EN
                        last_grant <= grant;
`endif
                    end
                end
                REQ: begin
                    if (bus.mem_req_rdy) state <= RESP;
                end
                RESP: begin
                    if (bus.mem_resp_val && bus.mem_resp_rdy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameters: none; all address and data widths SHALL be fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 reqN_val / reqN_rdy (N=0,1)  in / out  1  request handshake; port 0 is imem, port 1 is dmem.
REQ-005 reqN_type  in  1  transaction type: 0 = read, 1 = write.
REQ-006 reqN_addr / reqN_wdata  in  32  request address / write data.
REQ-007 respN_val / respN_rdy  out / in  1  response handshake to requester N.
REQ-008 respN_rdata  out  32  response read data.
REQ-009 mem_req_val / mem_req_rdy  out / in  1  request handshake to the shared memory.
REQ-010 mem_req_type / mem_req_addr / mem_req_wdata  out  1/32/32  buffered request fields.
REQ-011 mem_resp_val / mem_resp_rdy / mem_resp_rdata  in / out / in  1/1/32  memory response handshake.

Function
REQ-012 A transfer on any val/rdy pair SHALL occur only in a cycle where val and rdy are both high at the rising edge.
REQ-013 The FSM SHALL have three states: IDLE, REQ and RESP; exactly one memory transaction SHALL be outstanding at a time.
REQ-014 IDLE behaviour:
- Arbitration SHALL raise reqN_rdy only for the granted port; all other rdy outputs SHALL be 0.
- No request pending: SHALL stay in IDLE, and all rdy outputs SHALL be 0 except the rdy of the port that would be granted.
REQ-015 On a request handshake in IDLE:
- SHALL latch type, addr and wdata into the request buffer.
- SHALL record the owner port.
- SHALL go to REQ.
REQ-016 REQ behaviour:
- mem_req_val SHALL be 1 with the buffered fields.
- On mem_req_rdy SHALL go to RESP.
- mem_req_val SHALL be 0 in IDLE and RESP.
REQ-017 RESP behaviour:
- Owner side: resp[owner]_val SHALL equal mem_resp_val, and resp[owner]_rdata SHALL equal mem_resp_rdata.
- Memory side: mem_resp_rdy SHALL equal resp[owner]_rdy.
- Non-owner respN_val SHALL be 0.
- On the response handshake SHALL return to IDLE.
REQ-018 Writes SHALL receive a response like reads; the rdata of a write response is don't-care.
REQ-019 Minimum latency:
- Accept at cycle 0, mem_req_val at cycle 1.
- With a zero-wait memory, the response is visible at cycle 2.
- A new grant is possible at cycle 3.
REQ-020 Simultaneous reqN_val on both ports SHALL grant exactly one port, selected by the policy in REQ-027.
REQ-021 Requester inputs SHALL be ignored outside IDLE; the request buffer SHALL hold stable from REQ until RESP completes.
REQ-022 The round-robin pointer SHALL update only on a request handshake, and SHALL then point to the port just granted.

Reset
REQ-023 On reset assertion all outputs SHALL go low asynchronously: rdy, val, mem_req_* and respN_rdata.
REQ-024 Reset SHALL set the FSM to IDLE, clear the request buffer and owner to 0, and set last-grant to port 1, so that port 0 wins first.
REQ-025 Reset mid-transaction SHALL abandon the transaction; no response SHALL be delivered afterwards, and mem_resp_rdy SHALL be 0.
REQ-026 On deassertion the block SHALL act on the first rising edge.

Configuration
REQ-027 Macro MEM_ARB_RR_EN SHALL select the arbitration policy:
- Defined: round-robin; on contention the port not equal to last-grant wins.
- Undefined: fixed priority, with port 1 (dmem) always winning contention and no pointer state present.
REQ-028 Uncontended behaviour SHALL be identical with and without the macro.

Structure
REQ-029 The FSM state enum and the MEM_RD=0 / MEM_WR=1 constants SHALL live in the shared TinyRV1 package.
REQ-030 The request buffer SHALL be one instance of the existing enabled Register sub-module, 65 bits wide, enabled on the IDLE request handshake; no other sub-module.

Verification
REQ-031 Single read: req0 read addr 0x100 with zero-wait memory returning 0xDEADBEEF -> mem_req_val at cycle 1 with addr 0x100; resp0_val with 0xDEADBEEF at cycle 2; resp1_val stays 0.
REQ-032 Contention: req0 and req1 both high every cycle, 4 transactions ->
- RR_EN defined: grants 0,1,0,1.
- RR_EN undefined: grants 1,1,1,1.
REQ-033 Backpressure:
- mem_req_rdy low for 3 cycles -> mem_req_val and fields held constant, reqN_rdy 0 throughout.
- resp1_rdy low for 2 cycles -> mem_resp_rdy low for those 2 cycles, then the transaction completes.
REQ-034 Write: req1 write addr 0x200 data 0x12345678 -> mem_req_type=1 with those fields; resp1_val delivered; the FSM returns to IDLE.
REQ-035 Reset mid-RESP with mem_resp_val high -> all outputs 0 immediately; after release, req0 is granted first even with req1 pending (RR_EN defined).
